shift_unit_pipe: RTL and testbench
==================================

Name: shift_unit_pipe

Overview:
- Parametrised, two-stage pipelined log-barrel shifter for the EX stage of the MIPS pipeline.
- Generalises the single-cycle shift-left block:
  - adds SLL/SRL/SRA/ROR modes
  - WIDTH is parametrised
  - adds valid/ready handshaking with backpressure and a synchronous flush
- Produces result plus C/V/N/Z flags two cycles after acceptance.

Parameters:
WIDTH, 32, data width in bits; power of two, 8..64
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
SPLIT, SHW/2, number of log levels (1,2,4,..) done in stage 1; remaining levels in stage 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous; clears both pipeline stages
in_valid  in  1  operand valid
in_ready  out  1  unit can accept this cycle
T  in  WIDTH  operand
shamt  in  SHW  shift amount, unsigned
op  in  2  0=SLL 1=SRL 2=SRA 3=ROR
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
Y_lo  out  WIDTH  shifted result
C  out  1  carry flag
V  out  1  overflow flag
N  out  1  negative flag
Z  out  1  zero flag

Behaviour:
- Reset (async, any time including mid-operation): s1_valid=s2_valid=0; all data/flag registers=0; out_valid=0, Y_lo=0, C=V=N=Z=0. in_ready is 1 in the first cycle after reset deasserts.
- Stage 1 register: accept on in_valid && in_ready. Store T partially shifted by shamt[SPLIT-1:0] (levels 1,2,4..), plus op, shamt, and precomputed C and V.
- Stage 2 register: remaining levels applied; N and Z computed; feeds outputs directly from registers.
- Latency exactly 2 cycles from accept to out_valid when no stall. Throughput 1/cycle.
- Stall rules:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = !s1_valid || s2 advance. Combinational from out_ready; no skid buffer.
  - While out_valid && !out_ready: Y_lo and all flags hold stable.
- Fill rules by op:
  - SLL: zeros shifted in at LSB.
  - SRL: zeros shifted in at MSB.
  - SRA: copies of T[WIDTH-1] shifted in.
  - ROR: rotate right, no fill.
- Flags, for shamt=s>0:
  - C:
    - SLL: T[WIDTH-s]
    - SRL, SRA: T[s-1]
    - ROR: Y_lo[WIDTH-1]
  - V:
    - SLL: 1 iff bits T[WIDTH-1:WIDTH-1-s] not all equal (signed overflow).
    - All other ops: 0.
  - N = Y_lo[WIDTH-1]
  - Z = (Y_lo == 0)
- shamt=0: Y_lo=T for every op; C=0, V=0; N and Z per result.
- Flags are never X.
- flush: next edge clears s1_valid and s2_valid. Data registers may keep stale values. If in_valid is high in the same cycle as flush, the input is dropped. flush has priority over accept and advance.
- Simultaneous accept and output-consume in a full pipe: all three transactions occur in the same cycle; no bubble.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings: OP_SLL=2'd0, OP_SRL=2'd1, OP_SRA=2'd2, OP_ROR=2'd3
  - a flag-struct typedef {C,V,N,Z}
- One sub-module: shift_level, a combinational single log level. Parameters: WIDTH, AMT. Inputs: data, enable, op, fill bit. Instantiated SHW times via generate and split across the two stages.
- Handshake and flag logic live in the top module.

Test Plan:
- SLL, T=32'h4000_0001, shamt=1, no stall -> out_valid exactly 2 cycles after accept; Y_lo=32'h8000_0002, C=0, V=1, N=1, Z=0.
- SRA, T=32'h8000_0000, shamt=31 -> Y_lo=32'hFFFF_FFFF, C=0, N=1. SRL with same inputs -> Y_lo=32'h0000_0001, C=0, N=0. ROR, T=32'h0000_0001, shamt=1 -> Y_lo=32'h8000_0000, C=1.
- shamt=0 for all four ops with T=32'h0 -> Y_lo=0, Z=1, C=V=N=0.
- Backpressure: stream 4 back-to-back ops while out_ready is held low from cycle 2 for 3 cycles -> in_ready falls after 2 accepts, Y_lo holds stable, and all 4 results emerge in order with no loss or duplication.
- Flush: pipe full (2 in flight) with flush and in_valid both high -> next cycle out_valid=0, s1 empty, and the flushed-cycle input never appears at the output.
- Reset asserted asynchronously mid-stall, between clock edges -> out_valid, Y_lo and flags go to 0 immediately; after release, a new SLL 32'h1 by 4 yields 32'h10 after 2 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and flag bundle.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROR = 2'd3
  } shift_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/shift_level.sv
// One combinational log level of the barrel shifter: shifts by AMT when enabled.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic [1:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ONES = '1;

  // fill is already qualified by the caller (sign bit for SRA, 0 for SRL)
  logic [WIDTH-1:0] fill_mask;
  assign fill_mask = fill ? ~(ONES >> AMT) : '0;

  always_comb begin
    y = data;
    if (enable) begin
      case (op)
        OP_SLL:         y = data << AMT;
        OP_SRL, OP_SRA: y = (data >> AMT) | fill_mask;
        default:        y = (data >> AMT) | (data << (WIDTH - AMT));
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined log-barrel shifter (SLL/SRL/SRA/ROR) with C/V/N/Z flags,
// valid/ready handshaking, backpressure and synchronous flush.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPLIT = $clog2(WIDTH) / 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         T,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [1:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         Y_lo,
  output logic                     C,
  output logic                     V,
  output logic                     N,
  output logic                     Z
);

  localparam int SHW = $clog2(WIDTH);
  localparam int HI  = SHW - SPLIT;
  localparam logic [WIDTH-1:0] ONES = '1;

  // Handshake: a transfer happens on a stage boundary when valid && ready are
  // both high at a rising edge. Stage 2 moves when empty or drained; stage 1
  // moves when empty or stage 2 moves; in_ready is that stage-1 condition and
  // so depends combinationally on out_ready (no skid buffer).
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, accept;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;

  // Stage 1 datapath: low log levels applied to T
  logic [SPLIT:0][WIDTH-1:0] s1_chain;
  logic                      fill_in;

  assign s1_chain[0] = T;
  assign fill_in     = (op == OP_SRA) && T[WIDTH-1];

  for (genvar k = 0; k < SPLIT; k++) begin : g_s1
    shift_level #(.WIDTH(WIDTH), .AMT(1 << k)) u_lvl (
      .data   (s1_chain[k]),
      .enable (shamt[k]),
      .op     (op),
      .fill   (fill_in),
      .y      (s1_chain[k+1])
    );
  end

  // C is a single bit of T; -s mod WIDTH equals WIDTH-s whenever s > 0.
  // For ROR, result MSB is T[s-1], same as the right-shift case.
  logic [SHW-1:0]   neg_s, s_m1;
  logic [WIDTH-1:0] hi_mask, win;
  logic             c_in, v_in;

  assign neg_s   = '0 - shamt;
  assign s_m1    = shamt - SHW'(1);
  assign c_in    = (shamt != '0) && ((op == OP_SLL) ? T[neg_s] : T[s_m1]);
  assign hi_mask = ~(ONES >> shamt);
  assign win     = hi_mask | (hi_mask >> 1);
  assign v_in    = (op == OP_SLL) && (shamt != '0) &&
                   ((T & win) != '0) && ((T & win) != win);

  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_op;
  logic [HI-1:0]    s1_shamt_hi;
  logic             s1_c, s1_v;

  // Stage 2 datapath: remaining high log levels; SRA sign survives stage 1
  logic [HI:0][WIDTH-1:0] s2_chain;
  logic                   fill_s2;
  logic [WIDTH-1:0]       y2;

  assign s2_chain[0] = s1_data;
  assign fill_s2     = (s1_op == OP_SRA) && s1_data[WIDTH-1];
  assign y2          = s2_chain[HI];

  for (genvar k = 0; k < HI; k++) begin : g_s2
    shift_level #(.WIDTH(WIDTH), .AMT(1 << (k + SPLIT))) u_lvl (
      .data   (s2_chain[k]),
      .enable (s1_shamt_hi[k]),
      .op     (s1_op),
      .fill   (fill_s2),
      .y      (s2_chain[k+1])
    );
  end

  logic [WIDTH-1:0] s2_data;
  flags_t           s2_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_op       <= '0;
      s1_shamt_hi <= '0;
      s1_c        <= 1'b0;
      s1_v        <= 1'b0;
      s2_valid    <= 1'b0;
      s2_data     <= '0;
      s2_flags    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_data     <= s1_chain[SPLIT];
        s1_op       <= op;
        s1_shamt_hi <= shamt[SHW-1:SPLIT];
        s1_c        <= c_in;
        s1_v        <= v_in;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_data    <= y2;
        s2_flags.c <= s1_c;
        s2_flags.v <= s1_v;
        s2_flags.n <= y2[WIDTH-1];
        s2_flags.z <= (y2 == '0);
      end
    end
  end

  assign out_valid = s2_valid;
  assign Y_lo      = s2_data;
  assign C         = s2_flags.c;
  assign V         = s2_flags.v;
  assign N         = s2_flags.n;
  assign Z         = s2_flags.z;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed vector table, backpressure/flush/reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic          c, v, n, z;
  logic [W-1:0]  t, y_lo;
  logic [SW-1:0] shamt;
  logic [1:0]    op;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  logic [W+3:0] exp_q[$];
  logic         held_vld;
  logic [W+3:0] held;

  typedef struct packed {
    logic [1:0]    op;
    logic [SW-1:0] sh;
    logic [W-1:0]  t;
    logic [W+3:0]  exp;
  } vec_t;
  vec_t vecs[14];

  shift_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .T         (t),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y_lo      (y_lo),
    .C         (c),
    .V         (v),
    .N         (n),
    .Z         (z)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: result from plain shift operators; V means the left shift is
  // not reversible by an arithmetic right shift of the same amount.
  function automatic logic [W+3:0] model(input logic [1:0] o, input int s,
                                         input logic [W-1:0] tv);
    logic [W-1:0]        y;
    logic signed [W-1:0] ys, ts;
    logic                cf, vf;
    case (o)
      2'd0:    y = tv << s;
      2'd1:    y = tv >> s;
      2'd2:    y = $unsigned($signed(tv) >>> s);
      default: y = (s == 0) ? tv : ((tv >> s) | (tv << (W - s)));
    endcase
    ys = y;
    ts = tv;
    cf = 1'b0;
    vf = 1'b0;
    if (s != 0) begin
      if (o == 2'd0)      cf = tv[W-s];
      else if (o == 2'd3) cf = y[W-1];
      else                cf = tv[s-1];
      vf = (o == 2'd0) && ((ys >>> s) != ts);
    end
    return {y, cf, vf, y[W-1], (y == '0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  // one cycle: scoreboard at negedge, then advance past the next posedge
  task automatic step();
    logic [W+3:0] got;
    @(negedge clk);
    got = {y_lo, c, v, n, z};
    if (held_vld && out_valid) check("hold", got, held);
    held_vld = out_valid && !out_ready && !flush;
    held     = got;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: act=%h exp=none", got);
      end else begin
        check("out", got, exp_q.pop_front());
      end
    end
    if (flush) exp_q.delete();
    else if (in_valid && in_ready) begin
      exp_q.push_back(model(op, int'(shamt), t));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [1:0] o, input logic [SW-1:0] s,
                         input logic [W-1:0] tv, input logic [W-1:0] y,
                         input logic [3:0] f);
    vecs[i] = '{o, s, tv, {y, f}};
  endtask

  task automatic drive_rand();
    op    = 2'($urandom_range(0, 3));
    shamt = SW'($urandom_range(0, W - 1));
    case ($urandom_range(0, 4))
      0:       t = '0;
      1:       t = '1;
      2:       t = 32'h8000_0000;
      default: t = $urandom();
    endcase
  endtask

  initial begin
    int base;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    t = '0; shamt = '0; op = '0; held_vld = 1'b0;

    // flags order {C,V,N,Z}
    set_vec(0,  OP_SLL, 5'd1,  32'h4000_0001, 32'h8000_0002, 4'b0110);
    set_vec(1,  OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0010);
    set_vec(2,  OP_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 4'b0000);
    set_vec(3,  OP_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 4'b1010);
    set_vec(4,  OP_SLL, 5'd0,  32'h0,         32'h0,         4'b0001);
    set_vec(5,  OP_SRL, 5'd0,  32'h0,         32'h0,         4'b0001);
    set_vec(6,  OP_SRA, 5'd0,  32'h0,         32'h0,         4'b0001);
    set_vec(7,  OP_ROR, 5'd0,  32'h0,         32'h0,         4'b0001);
    set_vec(8,  OP_SLL, 5'd1,  32'h8000_0000, 32'h0,         4'b1101);
    set_vec(9,  OP_SRL, 5'd1,  32'h0000_0003, 32'h0000_0001, 4'b1000);
    set_vec(10, OP_ROR, 5'd0,  32'h1234_5678, 32'h1234_5678, 4'b0000);
    set_vec(11, OP_SLL, 5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFF0, 4'b1010);
    set_vec(12, OP_SRA, 5'd4,  32'h7FFF_FFFF, 32'h07FF_FFFF, 4'b1000);
    set_vec(13, OP_ROR, 5'd8,  32'h0000_00F0, 32'hF000_0000, 4'b1010);

    #12;
    check("rst_outputs", {out_valid, y_lo, c, v, n, z}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // directed vectors: latency exactly two cycles, constant expectations
    for (int i = 0; i < 14; i++) begin
      op = vecs[i].op; shamt = vecs[i].sh; t = vecs[i].t;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("tbl%0d_rdy", i), in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("tbl%0d_lat1", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("tbl%0d_lat2", i), out_valid, 1);
      check($sformatf("tbl%0d_res", i), {y_lo, c, v, n, z}, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // backpressure: 4 back-to-back ops, out_ready low for cycles 2..4
    base = n_acc;
    for (int k = 0; k < 12; k++) begin
      out_ready = !(k >= 2 && k < 5);
      in_valid  = (n_acc - base) < 4;
      if (k == 0 || !in_valid || in_ready) drive_rand();
      #1;
      if (k == 2) check("bp_in_ready_low", in_ready, 0);
      step();
    end
    check("bp_accepts", n_acc - base, 4);
    check("bp_drained", exp_q.size(), 0);

    // flush with a full pipe and a concurrent input
    out_ready = 1'b0; in_valid = 1'b1;
    drive_rand(); step();
    drive_rand(); step();
    flush = 1'b1; t = 32'hDEAD_BEEF; shamt = 5'd3; op = OP_SRL;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_out_valid", out_valid, 0);
    check("fl_s1_empty", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) step();

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0; in_valid = 1'b1; op = OP_SLL; shamt = 5'd3;
    t = $urandom() | 32'h1;
    step(); step();
    in_valid = 1'b0;
    step();
    #2;
    check("rst_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_async", {out_valid, y_lo, c, v, n, z}, '0);
    exp_q.delete();
    held_vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rel_ready", in_ready, 1);
    op = OP_SLL; t = 32'h1; shamt = 5'd4; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1;
    check("rst_new_result", {out_valid, y_lo}, {1'b1, 32'h10});
    step();

    // randomized traffic with random stalls and occasional flush
    for (int k = 0; k < 400; k++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 49) == 0;
      drive_rand();
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
